// File: rtl/ca_keystream_gen.sv
// Hybrid rule 90/150 cellular-automaton keystream generator.
// Loads a nonzero seed, discards WARMUP steps, then emits len words over valid/ready.

module ca_cell #(
    parameter bit RULE150 = 1'b0
) (
    input  logic left,
    input  logic mid,
    input  logic right,
    output logic nxt
);
    assign nxt = left ^ right ^ (RULE150 & mid);
endmodule

module ca_keystream_gen #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RULE_MASK = 'h01,
    parameter int               WARMUP    = 8,
    parameter int               LEN_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] seed,
    input  logic [LEN_W-1:0] len,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic             seed_err
);
    typedef enum logic [1:0] {IDLE, WARM, RUN} state_t;

    localparam logic [7:0] WARM_INIT = 8'(WARMUP);

    state_t           st;
    logic [WIDTH-1:0] ca;
    logic [WIDTH-1:0] ca_nxt;
    logic [LEN_W-1:0] remaining;
    logic [7:0]       wcnt;
    logic [WIDTH+1:0] pad;

    // Zero cells on both ends give the null boundary.
    assign pad = {1'b0, ca, 1'b0};

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        ca_cell #(.RULE150(RULE_MASK[i])) u_cell (
            .left  (pad[i+2]),
            .mid   (pad[i+1]),
            .right (pad[i]),
            .nxt   (ca_nxt[i])
        );
    end

    assign out_data = ca;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st        <= IDLE;
            ca        <= '0;
            remaining <= '0;
            wcnt      <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            seed_err  <= 1'b0;
        end else begin
            done     <= 1'b0;
            seed_err <= 1'b0;
            if (abort) begin
                // The CA state is left as-is so the last word remains observable.
                st        <= IDLE;
                out_valid <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (st)
                    IDLE: begin
                        if (start) begin
                            if (seed == '0) begin
                                seed_err <= 1'b1;
                            end else if (len == '0) begin
                                done <= 1'b1;
                            end else begin
                                ca        <= seed;
                                remaining <= len;
                                wcnt      <= WARM_INIT;
                                busy      <= 1'b1;
                                st        <= (WARMUP == 0) ? RUN : WARM;
                                out_valid <= (WARMUP == 0);
                            end
                        end
                    end
                    WARM: begin
                        ca <= ca_nxt;
                        if (wcnt != '0) wcnt <= wcnt - 8'd1;
                        if (wcnt <= 8'd1) begin
                            st        <= RUN;
                            out_valid <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (out_valid && out_ready) begin
                            ca <= ca_nxt;
                            if (remaining != '0) remaining <= remaining - LEN_W'(1);
                            if (remaining <= LEN_W'(1)) begin
                                st        <= IDLE;
                                out_valid <= 1'b0;
                                busy      <= 1'b0;
                                done      <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        st        <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ca_keystream_gen.sv
// Bench for ca_keystream_gen: two instances (WARMUP=2 and WARMUP=0) driven in lockstep
// against a behavioural model, plus hand-computed word sequences.

module tb_ca_keystream_gen;
    localparam int LW = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          out_ready = 1'b1;
    logic [3:0]    seed = '0;
    logic [LW-1:0] len = '0;

    logic [3:0] o_data [2];
    logic       o_valid [2];
    logic       o_busy [2];
    logic       o_done [2];
    logic       o_serr [2];

    int ncmp = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    ca_keystream_gen #(.WIDTH(4), .RULE_MASK(4'b0001), .WARMUP(2), .LEN_W(LW)) dut_a (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .seed(seed), .len(len),
        .out_data(o_data[0]), .out_valid(o_valid[0]), .out_ready(out_ready),
        .busy(o_busy[0]), .done(o_done[0]), .seed_err(o_serr[0]));

    ca_keystream_gen #(.WIDTH(4), .RULE_MASK(4'b0001), .WARMUP(0), .LEN_W(LW)) dut_b (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .seed(seed), .len(len),
        .out_data(o_data[1]), .out_valid(o_valid[1]), .out_ready(out_ready),
        .busy(o_busy[1]), .done(o_done[1]), .seed_err(o_serr[1]));

    task automatic chk(input string nm, input int act, input int exp);
        ncmp++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Rule 90 is left ^ right neighbour; rule 150 adds the cell itself.
    function automatic logic [3:0] ca_step(input logic [3:0] c);
        return 4'((c << 1) ^ (c >> 1) ^ (c & 4'b0001));
    endfunction

    function automatic int warm_of(input int k);
        return (k == 0) ? 2 : 0;
    endfunction

    // Model: mode 0 idle, 1 discarding warm-up steps, 2 offering words.
    int         m_mode [2];
    logic [3:0] m_data [2];
    int         m_rem [2];
    int         m_wc [2];
    bit         m_done [2];
    bit         m_serr [2];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                m_mode[k] = 0; m_data[k] = '0; m_rem[k] = 0; m_wc[k] = 0;
                m_done[k] = 0; m_serr[k] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                m_done[k] = 0;
                m_serr[k] = 0;
                if (abort) m_mode[k] = 0;
                else if (m_mode[k] == 0) begin
                    if (start) begin
                        if (seed == 0) m_serr[k] = 1;
                        else if (len == 0) m_done[k] = 1;
                        else begin
                            m_data[k] = seed;
                            m_rem[k]  = int'(len);
                            m_wc[k]   = warm_of(k);
                            m_mode[k] = (m_wc[k] > 0) ? 1 : 2;
                        end
                    end
                end else if (m_mode[k] == 1) begin
                    m_data[k] = ca_step(m_data[k]);
                    m_wc[k]   = m_wc[k] - 1;
                    if (m_wc[k] == 0) m_mode[k] = 2;
                end else if (out_ready) begin
                    m_data[k] = ca_step(m_data[k]);
                    m_rem[k]  = m_rem[k] - 1;
                    if (m_rem[k] == 0) begin
                        m_mode[k] = 0;
                        m_done[k] = 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("dut%0d.out_data", k), int'(o_data[k]), int'(m_data[k]));
            chk($sformatf("dut%0d.out_valid", k), int'(o_valid[k]), int'(m_mode[k] == 2));
            chk($sformatf("dut%0d.busy", k), int'(o_busy[k]), int'(m_mode[k] != 0));
            chk($sformatf("dut%0d.done", k), int'(o_done[k]), int'(m_done[k]));
            chk($sformatf("dut%0d.seed_err", k), int'(o_serr[k]), int'(m_serr[k]));
        end
    end

    logic [3:0] qa [$];
    logic [3:0] qb [$];
    int nd [2];
    int nw [2];

    task automatic go(input logic [3:0] s, input int l);
        @(negedge clk);
        start = 1'b1;
        seed  = s;
        len   = LW'(l);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Gather accepted words of both instances until both have pulsed done.
    task automatic collect(input int bound, input bit ign);
        bit fin;
        fin = 0;
        qa.delete(); qb.delete();
        nd = '{0, 0}; nw = '{0, 0};
        for (int i = 0; i < bound && !fin; i++) begin
            if (o_valid[0] && out_ready) qa.push_back(o_data[0]);
            if (o_valid[1] && out_ready) qb.push_back(o_data[1]);
            for (int k = 0; k < 2; k++) begin
                if (o_done[k]) nd[k]++;
                if (o_busy[k] && !o_valid[k]) nw[k]++;
            end
            fin = (nd[0] > 0) && (nd[1] > 0);
            if (ign && i < 2) begin
                start = 1'b1; seed = 4'hF; len = LW'(1);
            end else start = 1'b0;
            if (!fin) @(negedge clk);
        end
        start = 1'b0;
        if (!fin) chk("collect_timeout", 0, 1);
    endtask

    initial begin
        int hs;
        repeat (2) @(negedge clk);
        chk("reset.out_data", int'(o_data[0]), 0);
        chk("reset.busy", int'(o_busy[0]), 0);
        chk("reset.out_valid", int'(o_valid[1]), 0);
        reset = 1'b1;

        // 1: basic sequence
        go(4'b0001, 3);
        collect(30, 0);
        chk("t1.count", qa.size(), 3);
        if (qa.size() == 3) begin
            chk("t1.w0", int'(qa[0]), 4'b0110);
            chk("t1.w1", int'(qa[1]), 4'b1111);
            chk("t1.w2", int'(qa[2]), 4'b1000);
        end
        chk("t1.warm_cycles", nw[0], 2);
        chk("t1.done_count", nd[0], 1);
        if (qb.size() > 0) chk("t1.b_w0", int'(qb[0]), 4'b0001);
        @(negedge clk);
        chk("t1.done_after", int'(o_done[0]), 0);
        chk("t1.valid_after", int'(o_valid[0]), 0);

        // 2: backpressure on the first word
        out_ready = 1'b0;
        go(4'b0001, 3);
        hs = 0;
        while (!o_valid[0] && hs < 20) begin @(negedge clk); hs++; end
        if (hs >= 20) chk("t2.valid_timeout", 0, 1);
        for (int i = 0; i < 5; i++) begin
            chk("t2.stall_data", int'(o_data[0]), 4'b0110);
            chk("t2.stall_valid", int'(o_valid[0]), 1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        collect(30, 0);
        chk("t2.count", qa.size(), 3);
        if (qa.size() == 3) begin
            chk("t2.w0", int'(qa[0]), 4'b0110);
            chk("t2.w1", int'(qa[1]), 4'b1111);
            chk("t2.w2", int'(qa[2]), 4'b1000);
        end

        // 3: zero seed, zero length
        go(4'b0000, 3);
        chk("t3.seed_err", int'(o_serr[0]), 1);
        chk("t3.busy", int'(o_busy[0]), 0);
        @(negedge clk);
        chk("t3.seed_err_clear", int'(o_serr[0]), 0);
        go(4'b0001, 0);
        chk("t3.done", int'(o_done[0]), 1);
        chk("t3.valid", int'(o_valid[0]), 0);
        @(negedge clk);
        chk("t3.done_clear", int'(o_done[0]), 0);

        // 4: abort after the second accepted word
        go(4'b0001, 10);
        hs = 0;
        for (int i = 0; i < 20 && hs < 2; i++) begin
            if (o_valid[0] && out_ready) hs++;
            if (hs < 2) @(negedge clk);
        end
        chk("t4.handshakes", hs, 2);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t4.valid", int'(o_valid[0]), 0);
        chk("t4.busy", int'(o_busy[0]), 0);
        chk("t4.done", int'(o_done[0]), 0);
        go(4'b1000, 2);
        collect(30, 0);
        chk("t4.count", qa.size(), 2);
        if (qa.size() == 2) begin
            chk("t4.w0", int'(qa[0]), 4'b1010);
            chk("t4.w1", int'(qa[1]), 4'b0001);
        end
        if (qb.size() == 2) begin
            chk("t4.b_w0", int'(qb[0]), 4'b1000);
            chk("t4.b_w1", int'(qb[1]), 4'b0100);
        end else chk("t4.b_count", qb.size(), 2);

        // 5: async reset during warm-up
        go(4'b0001, 5);
        #2 reset = 1'b0;
        #1;
        chk("t5.data_async", int'(o_data[0]), 0);
        chk("t5.busy_async", int'(o_busy[0]), 0);
        chk("t5.b_valid_async", int'(o_valid[1]), 0);
        @(negedge clk);
        reset = 1'b1;
        go(4'b0001, 2);
        collect(30, 0);
        chk("t5.b_count", qb.size(), 2);
        if (qb.size() > 0) chk("t5.b_w0", int'(qb[0]), 4'b0001);
        if (qa.size() > 0) chk("t5.a_w0", int'(qa[0]), 4'b0110);

        // 6: start while busy is ignored
        go(4'b0001, 3);
        collect(30, 1);
        chk("t6.count", qa.size(), 3);
        if (qa.size() == 3) begin
            chk("t6.w0", int'(qa[0]), 4'b0110);
            chk("t6.w1", int'(qa[1]), 4'b1111);
            chk("t6.w2", int'(qa[2]), 4'b1000);
        end
        chk("t6.b_count", qb.size(), 3);

        // 7: maximum length completes without wrap
        go(4'b0001, (1 << LW) - 1);
        collect(300, 0);
        chk("t7.count", qa.size(), (1 << LW) - 1);
        chk("t7.done_count", nd[0], 1);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule

// File: doc/ca_keystream_gen.md
Name: ca_keystream_gen

Overview:
Cellular-automaton keystream generator built on a row of D-flop cells using a hybrid rule 90/150 update.
- Loads a nonzero seed and runs a programmable warm-up.
- Then emits LEN words of CA state over a valid/ready handshake.
- Sits directly upstream of the ECC/MAC datapath, which consumes the words as mask/key material.

Parameters:
WIDTH, 8, number of CA cells and output word width (≥2).
RULE_MASK, 8'h01, per-cell rule select: bit i=1 means cell i uses rule 150, 0 means rule 90.
WARMUP, 8, CA steps discarded after seed load before the first output word (0 allowed).
LEN_W, 16, width of the word-count input.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (asserted when 0)
start  input  1  begin a run; sampled only in IDLE
abort  input  1  synchronous abort of any run
seed  input  WIDTH  initial CA state, sampled with start
len  input  LEN_W  number of words to emit, sampled with start
out_data  output  WIDTH  current CA state word
out_valid  output  1  out_data is a valid keystream word
out_ready  input  1  downstream accepts the word
busy  output  1  high in WARMUP or RUN
done  output  1  one-cycle pulse after the last word is accepted, or after a len==0 start
seed_err  output  1  one-cycle pulse when start is given with seed==0

Behaviour:
- Reset (reset==0, async):
  - state register=0, counters=0, FSM=IDLE.
  - out_valid=0, busy=0, done=0, seed_err=0, out_data=0.
  - Released synchronously: first active edge after reset rises.
- CA step, null boundaries:
  - nxt[i] = cur[i+1] ^ cur[i-1] ^ (RULE_MASK[i] & cur[i]).
  - cur[WIDTH] and cur[-1] are taken as 0.
- All outputs are registered; out_data is the state register.
- Priority per edge: reset > abort > FSM.
- IDLE:
  - out_valid=0, busy=0.
  - start && seed==0: seed_err=1 next cycle; remain IDLE.
  - start && seed!=0 && len==0: done=1 next cycle; remain IDLE; state unchanged.
  - start && seed!=0 && len!=0:
    - Load state<=seed, remaining<=len, wcnt<=WARMUP.
    - Go to WARMUP, or directly to RUN if WARMUP==0.
- WARMUP:
  - busy=1, out_valid=0.
  - Every cycle: one CA step, wcnt--.
  - Exactly WARMUP steps are performed; the edge that performs the last step moves to RUN.
  - out_ready is ignored.
- RUN:
  - busy=1, out_valid=1.
  - Handshake = out_valid && out_ready.
  - On a handshake: one CA step, remaining--.
  - Without a handshake: state, out_data and out_valid hold stable (no advance).
  - Handshake with remaining==1: FSM goes to IDLE, out_valid=0 and busy=0 next cycle, done=1 for exactly that cycle.
- abort, any state: next cycle FSM=IDLE, out_valid=0, busy=0; no done pulse; state register keeps its value.
- start while busy: ignored, including its seed and len.
- start in the same cycle done is high: accepted, because the FSM is already IDLE.
- Counters: remaining is LEN_W bits, wcnt is 8 bits.
  - len = 2^LEN_W-1 must complete without wrap.
  - Counters never underflow: they decrement only while nonzero.
- Mid-run reset: immediate return to the reset values above; no done pulse.

Test Plan:
1. Reset, then CA sequence.
   - Config: WIDTH=4, RULE_MASK=4'b0001, WARMUP=2, out_ready=1.
   - Stimulus: start, seed=4'b0001, len=3.
   - Required: busy for 2 warm-up cycles, then out_data 0110, 1111, 1000 on three consecutive valid cycles; done pulses once; out_valid=0 afterwards.
2. Backpressure.
   - Stimulus: same run as 1, out_ready=0 for 5 cycles on the first word.
   - Required: out_data holds 0110 with out_valid=1 throughout the stall; the sequence then resumes 1111, 1000 unchanged.
3. Zero seed and zero length.
   - Stimulus: start with seed=0. Then start with seed=4'b0001, len=0.
   - Required: first gives a seed_err one-cycle pulse, busy=0. Second gives a done one-cycle pulse, out_valid never asserted.
4. Abort mid-run.
   - Stimulus: len=10, abort asserted after the 2nd accepted word.
   - Required: next cycle out_valid=0, busy=0, no done pulse. A new start/seed then produces the correct sequence from the new seed.
5. Async reset mid-WARMUP.
   - Stimulus: drive reset=0 between clock edges during WARMUP.
   - Required: outputs go to 0 immediately, without waiting for clk. After release, start with WARMUP=0 gives seed 0001 as the first word.
6. Ignored start.
   - Stimulus: start pulses with a different seed while busy.
   - Required: the run in progress is unaffected; word count and values are unchanged.
